// File: rtl/mux_arb_nb_if.sv
// Channel-side and output-side signals of the mux/arbiter, bundled so the top
// keeps only clk/rst as plain ports.
interface mux_arb_nb_if #(
  parameter int n  = 8,
  parameter int CH = 4
);
  logic              mode;
  logic [2:0]        sel;
  logic [CH*n-1:0]   d_in;
  logic [CH-1:0]     valid;
  logic [CH-1:0]     ready;
  logic [n-1:0]      d_out;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        grant;

  modport slave (
    input  mode, sel, d_in, valid, out_ready,
    output ready, d_out, out_valid, grant
  );

  modport master (
    output mode, sel, d_in, valid, out_ready,
    input  ready, d_out, out_valid, grant
  );
endinterface

// File: rtl/mux_arb_nb.sv
// N-channel multiplexer with explicit-select or round-robin arbitration feeding
// a single-entry registered output that sustains one word per cycle.
module mux_arb_nb #(
  parameter int n  = 8,
  parameter int CH = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_arb_nb_if.slave bus
);

  logic [2:0]    pri;
  logic          found;
  logic [2:0]    cand;
  logic [n-1:0]  cand_data;
  logic [CH-1:0] ready_vec;
  logic          free;
  logic          xfer;
  logic [2:0]    pri_next;

  logic [n-1:0]  d_out_q;
  logic          out_valid_q;
  logic [2:0]    grant_q;

  // Candidate selection: explicit channel, or first valid at/after pri with wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    found = 1'b0;
    cand  = '0;
    if (!bus.mode) begin
      // An out-of-range sel matches no channel index, so it yields no candidate.
      for (int i = 0; i < CH; i++) begin
        if (3'(i) == bus.sel && bus.valid[i]) begin
          found = 1'b1;
          cand  = 3'(i);
        end
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!found && 3'(i) >= pri && bus.valid[i]) begin
          found = 1'b1;
          cand  = 3'(i);
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (!found && bus.valid[i]) begin
          found = 1'b1;
          cand  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (3'(i) == cand) cand_data = bus.d_in[i*n +: n];
    end
  end

  assign free = !out_valid_q || bus.out_ready;
  assign xfer = !rst && free && found;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < CH; i++) begin
      ready_vec[i] = xfer && (3'(i) == cand);
    end
  end

  assign pri_next = (cand == 3'(CH - 1)) ? 3'd0 : cand + 3'd1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      pri         <= '0;
    end else if (xfer) begin
      d_out_q     <= cand_data;
      grant_q     <= cand;
      out_valid_q <= 1'b1;
      if (bus.mode) pri <= pri_next;
    end else if (bus.out_ready) begin
      // Consumed with nothing to replace it: data and grant keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.ready     = ready_vec;
  assign bus.d_out     = d_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux_arb_nb.sv
// Bench for mux_arb_nb: two builds (8b x 4ch, 16b x 2ch) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_mux_arb_nb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_arb_nb_if #(.n(8),  .CH(4)) if0 ();
  mux_arb_nb_if #(.n(16), .CH(2)) if1 ();

  mux_arb_nb #(.n(8),  .CH(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_arb_nb #(.n(16), .CH(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int          pri;
    logic [63:0] dout;
    bit          ov;
    int          grant;
  } model_t;

  model_t m[2] = '{'{0, 64'd0, 1'b0, 0}, '{0, 64'd0, 1'b0, 0}};
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ch_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int w_of(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  // Candidate channel from the arbitration rules, or -1 when none.
  function automatic int find_cand(input int ch, input bit mode, input int sel,
                                   input logic [7:0] valid, input int pri);
    if (!mode) return (sel < ch && valid[sel]) ? sel : -1;
    for (int k = 0; k < ch; k++) begin
      int c;
      c = (pri + k) % ch;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] chan_word(input int d, input logic [63:0] din, input int c);
    int w;
    w = w_of(d);
    return (din >> (c * w)) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [7:0] exp_ready(input int d, input bit mode, input int sel,
                                           input logic [7:0] valid, input bit oready);
    int c;
    if (rst || !(!m[d].ov || oready)) return 8'd0;
    c = find_cand(ch_of(d), mode, sel, valid, m[d].pri);
    if (c < 0) return 8'd0;
    return 8'd1 << c;
  endfunction

  task automatic model_step(input int d, input bit mode, input int sel, input logic [7:0] valid,
                            input logic [63:0] din, input bit oready);
    int c;
    bit free;
    if (rst) begin
      m[d] = '{0, 64'd0, 1'b0, 0};
      return;
    end
    free = !m[d].ov || oready;
    c = find_cand(ch_of(d), mode, sel, valid, m[d].pri);
    if (free && c >= 0) begin
      m[d].dout  = chan_word(d, din, c);
      m[d].grant = c;
      m[d].ov    = 1'b1;
      if (mode) m[d].pri = (c + 1) % ch_of(d);
    end else if (oready) begin
      m[d].ov = 1'b0;
    end
  endtask

  task automatic compare(input int d, input bit mode, input int sel, input logic [7:0] valid,
                         input bit oready, input logic [7:0] act_ready, input logic [63:0] act_dout,
                         input logic act_ov, input logic [2:0] act_grant);
    check($sformatf("model_ready%0d", d), 64'(act_ready), 64'(exp_ready(d, mode, sel, valid, oready)));
    check($sformatf("model_dout%0d", d),  act_dout, m[d].dout);
    check($sformatf("model_ov%0d", d),    64'(act_ov), 64'(m[d].ov));
    check($sformatf("model_grant%0d", d), 64'(act_grant), 64'(m[d].grant));
  endtask

  always @(posedge clk) begin
    model_step(0, if0.mode, int'(if0.sel), 8'(if0.valid), 64'(if0.d_in), if0.out_ready);
    model_step(1, if1.mode, int'(if1.sel), 8'(if1.valid), 64'(if1.d_in), if1.out_ready);
  end

  always @(negedge clk) begin
    compare(0, if0.mode, int'(if0.sel), 8'(if0.valid), if0.out_ready,
            8'(if0.ready), 64'(if0.d_out), if0.out_valid, if0.grant);
    compare(1, if1.mode, int'(if1.sel), 8'(if1.valid), if1.out_ready,
            8'(if1.ready), 64'(if1.d_out), if1.out_valid, if1.grant);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if0.mode = 1'b1; if0.sel = 3'd0; if0.valid = 4'b1111;
    if0.d_in = 32'h13121110; if0.out_ready = 1'b0;
    if1.mode = 1'b0; if1.sel = 3'd0; if1.valid = 2'b00;
    if1.d_in = 32'hBBBBAAAA; if1.out_ready = 1'b0;

    // Reset state, with every channel requesting.
    cyc();
    at_neg();
    check("rst_ready", 64'(if0.ready), 64'h0);
    check("rst_dout",  64'(if0.d_out), 64'h0);
    check("rst_ov",    64'(if0.out_valid), 64'h0);
    check("rst_grant", 64'(if0.grant), 64'h0);

    // Explicit select of channel 2.
    cyc();
    rst = 1'b0;
    if0.mode = 1'b0; if0.sel = 3'd2; if0.valid = 4'b0100;
    if0.d_in = 32'h33A51100; if0.out_ready = 1'b1;
    at_neg();
    check("sel2_ready", 64'(if0.ready), 64'h4);
    cyc();
    if0.valid = 4'b0000;
    at_neg();
    check("sel2_dout",  64'(if0.d_out), 64'hA5);
    check("sel2_grant", 64'(if0.grant), 64'h2);
    check("sel2_ov",    64'(if0.out_valid), 64'h1);
    check("sel2_ready_after", 64'(if0.ready), 64'h0);

    // Out-of-range select never grants.
    cyc();
    if0.sel = 3'd5; if0.valid = 4'b1111; if0.d_in = 32'h13121110;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("sel5_ready", 64'(if0.ready), 64'h0);
      check("sel5_ov",    64'(if0.out_valid), 64'h0);
      cyc();
    end

    // Round-robin with all channels valid, full throughput.
    if0.mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      at_neg();
      check("rr_dout",  64'(if0.d_out), 64'(8'h10 + k % 4));
      check("rr_grant", 64'(if0.grant), 64'(k % 4));
    end

    // Hold a word, then reset over it.
    cyc();
    if0.valid = 4'b0000; if0.out_ready = 1'b0;
    at_neg();
    check("hold_ov", 64'(if0.out_valid), 64'h1);
    cyc();
    rst = 1'b1; if0.valid = 4'b1111;
    at_neg();
    check("rst_mid_ready", 64'(if0.ready), 64'h0);
    cyc();
    rst = 1'b0;
    if0.mode = 1'b1; if0.valid = 4'b1001; if0.out_ready = 1'b1;
    check("post_rst_dout",  64'(if0.d_out), 64'h0);
    check("post_rst_ov",    64'(if0.out_valid), 64'h0);
    check("post_rst_grant", 64'(if0.grant), 64'h0);
    at_neg();
    check("post_rst_ready", 64'(if0.ready), 64'h1);

    // Backpressure for three cycles, then channel 3 follows.
    cyc();
    if0.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      at_neg();
      check("bp_ready", 64'(if0.ready), 64'h0);
      check("bp_dout",  64'(if0.d_out), 64'h10);
      check("bp_grant", 64'(if0.grant), 64'h0);
      check("bp_ov",    64'(if0.out_valid), 64'h1);
    end
    cyc();
    if0.out_ready = 1'b1;
    at_neg();
    check("bp_release_ready", 64'(if0.ready), 64'h8);
    cyc();
    if0.valid = 4'b0000;
    at_neg();
    check("bp_next_dout",  64'(if0.d_out), 64'h13);
    check("bp_next_grant", 64'(if0.grant), 64'h3);

    // Two-channel 16-bit build: mode switch mid-stream, priority preserved.
    cyc();
    if1.mode = 1'b1; if1.valid = 2'b11; if1.d_in = 32'hBBBBAAAA; if1.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) begin
        if1.mode = 1'b0; if1.sel = 3'd1;
      end
      at_neg();
      check("w16_rr_grant", 64'(if1.grant), 64'(k % 2));
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) if1.mode = 1'b1;
      at_neg();
      check("w16_sel_grant", 64'(if1.grant), 64'h1);
      check("w16_sel_dout",  64'(if1.d_out), 64'hBBBB);
      check("w16_sel_ready", 64'(if1.ready), 64'h2);
    end
    cyc();
    at_neg();
    check("w16_back_grant", 64'(if1.grant), 64'h1);
    cyc();
    at_neg();
    check("w16_back_next", 64'(if1.grant), 64'h0);
    check("w16_back_dout", 64'(if1.d_out), 64'hAAAA);

    // Mixed vectors on both builds, checked by the model every cycle.
    for (int k = 0; k < 120; k++) begin
      cyc();
      rst = ($urandom_range(0, 24) == 0);
      if0.mode = 1'($urandom_range(0, 1));
      if0.sel = 3'($urandom_range(0, 7));
      if0.valid = 4'($urandom);
      if0.d_in = $urandom;
      if0.out_ready = ($urandom_range(0, 3) != 0);
      if1.mode = 1'($urandom_range(0, 1));
      if1.sel = 3'($urandom_range(0, 3));
      if1.valid = 2'($urandom);
      if1.d_in = $urandom;
      if1.out_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst = 1'b0;
    at_neg();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_nb.md
MUX_ARB_NB -- requirements
Module: mux_arb_nb

Interface
REQ-001 Parameter n, default 8, data width per channel in bits (1..32).
REQ-002 Parameter CH, default 4, number of input channels (2..8).
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 MODE  input  1  0 = explicit select, 1 = round-robin arbitration.
REQ-006 SEL  input  3  channel index used when MODE=0.
REQ-007 D_IN  input  CH*n  packed channel data; channel i occupies bits [i*n+n-1 : i*n].
REQ-008 VALID  input  CH  per-channel data-valid.
REQ-009 READY  output  CH  per-channel accept strobe; combinational, at most one bit high.
REQ-010 D_OUT  output  n  registered output data.
REQ-011 OUT_VALID  output  1  D_OUT holds an unconsumed word.
REQ-012 OUT_READY  input  1  downstream consumer accepts D_OUT this cycle.
REQ-013 GRANT  output  3  registered index of the channel that supplied the current D_OUT.

Function
REQ-014 Output stage SHALL be a single-entry register; slot is "free" when OUT_VALID=0 or OUT_READY=1 in the same cycle.
REQ-015 Candidate, MODE=0: channel SEL, provided SEL<CH and VALID[SEL]=1; SEL>=CH SHALL yield no candidate.
REQ-016 Candidate, MODE=1: first channel with VALID=1, searching upward from priority pointer PRI and wrapping CH-1 -> 0.
REQ-017 READY[c] SHALL be 1 only for the candidate c, and only when the slot is free; otherwise all READY=0.
REQ-018 Transfer occurs when VALID[c]=1 and READY[c]=1; on that edge D_OUT<=channel c data, GRANT<=c, OUT_VALID<=1.
REQ-019 Latency: data accepted at edge t SHALL appear on D_OUT with OUT_VALID=1 immediately after edge t (one cycle).
REQ-020 When OUT_READY=1 with OUT_VALID=1 and no transfer occurs, OUT_VALID<=0; D_OUT and GRANT SHALL hold their last values.
REQ-021 Simultaneous consume and transfer in one cycle SHALL load the new word with OUT_VALID staying 1 (full throughput, one word per cycle).
REQ-022 While OUT_VALID=1 and OUT_READY=0, D_OUT, GRANT and OUT_VALID SHALL hold and all READY=0.
REQ-023 PRI (width 3) SHALL update to (c+1) mod CH after each transfer in MODE=1; PRI SHALL hold in MODE=0 and when no transfer occurs.
REQ-024 MODE and SEL SHALL be sampled combinationally every cycle; a change takes effect in the same cycle and SHALL NOT disturb a word already held in D_OUT.
REQ-025 No channel with VALID=1 continuously SHALL wait more than CH-1 transfers in MODE=1 (starvation freedom).
REQ-026 VALID bits and data of non-granted channels SHALL have no effect on any output.

Reset
REQ-027 With RST=1 at a rising edge: D_OUT<=0, OUT_VALID<=0, GRANT<=0, PRI<=0.
REQ-028 While RST=1, READY SHALL be all 0 and no transfer SHALL occur, regardless of VALID, MODE or SEL.
REQ-029 Reset asserted while OUT_VALID=1 SHALL discard the held word; first post-reset MODE=1 arbitration starts at channel 0.

Verification
REQ-030 n=8, CH=4, MODE=0, SEL=2, VALID=4'b0100, D_IN ch2=8'hA5, OUT_READY=1 -> READY=4'b0100 one cycle, next cycle D_OUT=8'hA5, GRANT=2, OUT_VALID=1.
REQ-031 MODE=0, SEL=5 (>=CH), all VALID=1 -> READY=0 every cycle, OUT_VALID stays 0.
REQ-032 MODE=1, VALID=4'b1111 held, OUT_READY=1, ch i data=8'h10+i -> D_OUT sequence 10,11,12,13,10 on consecutive cycles, GRANT 0,1,2,3,0.
REQ-033 MODE=1, VALID=4'b1001, PRI=0 after reset, OUT_READY=0 after first transfer for 3 cycles -> D_OUT/GRANT hold 0, READY=0 for 3 cycles; on OUT_READY=1 ch3 transfers next.
REQ-034 Word held (OUT_VALID=1), RST pulsed one cycle -> D_OUT=0, OUT_VALID=0, GRANT=0 after the edge; subsequent MODE=1 grant goes to lowest valid channel.
REQ-035 CH=2, n=16 build, MODE switched 1->0 mid-stream with SEL=1 -> only channel 1 granted from that cycle; PRI unchanged on return to MODE=1.
